// File: rtl/ref_window_scan_ctrl.sv
// Reference window scan controller: owns the reference memory port, accepts window
// loads while idle, then streams every candidate block to the SAD engine.
module ref_window_scan_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int WIN_DIM    = 16,
    parameter int BLK_DIM    = 4,
    localparam int N  = WIN_DIM - BLK_DIM + 1,
    localparam int AW = $clog2(WIN_DIM * WIN_DIM),
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_start,
    input  logic                  in_load_valid,
    input  logic [AW-1:0]         in_load_addr,
    input  logic [DATA_WIDTH-1:0] in_load_data,
    output logic                  out_load_ready,
    output logic                  out_mem_write_en,
    output logic [AW-1:0]         out_mem_write_addr,
    output logic [DATA_WIDTH-1:0] out_mem_write_data,
    output logic [AW-1:0]         out_mem_read_addr,
    input  logic [DATA_WIDTH-1:0] in_mem_read_data,
    output logic                  out_pix_valid,
    output logic [DATA_WIDTH-1:0] out_pix_data,
    input  logic                  in_pix_ready,
    output logic                  out_pix_first,
    output logic                  out_pix_last,
    output logic [CW-1:0]         out_cand_x,
    output logic [CW-1:0]         out_cand_y,
    output logic                  out_busy,
    output logic                  out_done
);
    localparam int BW = (BLK_DIM > 1) ? $clog2(BLK_DIM) : 1;

    // state  | meaning
    // S_IDLE | window loads accepted, waiting for in_start
    // S_SCAN | issuing reads and presenting beats
    // S_DONE | one-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cx, r_cy, r_pres_cx, r_pres_cy;
    logic [BW-1:0]   r_bx, r_by;
    logic [AW-1:0]   r_pres_addr, w_issue_addr;
    logic            r_issue_done, r_valid, r_pres_first, r_pres_last, r_pres_end;
    logic            w_bx_last, w_by_last, w_cx_last, w_cy_last;
    logic            w_accept, w_stall, w_issue;

    assign w_bx_last = (r_bx == BW'(BLK_DIM - 1));
    assign w_by_last = (r_by == BW'(BLK_DIM - 1));
    assign w_cx_last = (r_cx == CW'(N - 1));
    assign w_cy_last = (r_cy == CW'(N - 1));

    assign w_accept = r_valid && in_pix_ready;
    assign w_stall  = r_valid && !in_pix_ready;
    assign w_issue  = (r_state == S_SCAN) && !r_issue_done && !w_stall;

    assign w_issue_addr = (AW'(r_cy) + AW'(r_by)) * AW'(WIN_DIM) + AW'(r_cx) + AW'(r_bx);

    // During a stall the presented address is re-read so the registered memory output holds.
    assign out_mem_read_addr = w_stall ? r_pres_addr : w_issue_addr;

    assign out_mem_write_en   = in_load_valid && out_load_ready;
    assign out_mem_write_addr = in_load_addr;
    assign out_mem_write_data = in_load_data;

    assign out_pix_valid = r_valid;
    assign out_pix_data  = in_mem_read_data;
    assign out_pix_first = r_valid && r_pres_first;
    assign out_pix_last  = r_valid && r_pres_last;
    assign out_cand_x    = r_pres_cx;
    assign out_cand_y    = r_pres_cy;

    always_comb begin
        w_state_nxt    = r_state;
        out_load_ready = 1'b0;
        out_busy       = 1'b0;
        out_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                out_load_ready = 1'b1;
                if (in_start) w_state_nxt = S_SCAN;
            end
            S_SCAN: begin
                out_busy = 1'b1;
                if (w_accept && r_pres_end) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_done    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state      <= S_IDLE;
            r_cx         <= '0;
            r_cy         <= '0;
            r_bx         <= '0;
            r_by         <= '0;
            r_pres_cx    <= '0;
            r_pres_cy    <= '0;
            r_pres_addr  <= '0;
            r_issue_done <= 1'b0;
            r_valid      <= 1'b0;
            r_pres_first <= 1'b0;
            r_pres_last  <= 1'b0;
            r_pres_end   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && in_start) r_issue_done <= 1'b0;
            if (w_issue) begin
                r_valid      <= 1'b1;
                r_pres_addr  <= w_issue_addr;
                r_pres_cx    <= r_cx;
                r_pres_cy    <= r_cy;
                r_pres_first <= (r_bx == '0) && (r_by == '0);
                r_pres_last  <= w_bx_last && w_by_last;
                r_pres_end   <= w_bx_last && w_by_last && w_cx_last && w_cy_last;
                // Counters wrap to zero after the final beat so IDLE reads address 0.
                if (w_bx_last) begin
                    r_bx <= '0;
                    if (w_by_last) begin
                        r_by <= '0;
                        if (w_cx_last) begin
                            r_cx <= '0;
                            if (w_cy_last) begin
                                r_cy         <= '0;
                                r_issue_done <= 1'b1;
                            end else begin
                                r_cy <= r_cy + 1'b1;
                            end
                        end else begin
                            r_cx <= r_cx + 1'b1;
                        end
                    end else begin
                        r_by <= r_by + 1'b1;
                    end
                end else begin
                    r_bx <= r_bx + 1'b1;
                end
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ref_window_scan_ctrl.sv
// Bench for ref_window_scan_ctrl: default 16/4 instance plus a 8/8 single-candidate instance,
// each with a registered-read memory model behind it.
module tb_ref_window_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, lv, ready;
    logic [7:0] la, ld;
    logic       wen, pv, pf, pl, busy, done, lr;
    logic [7:0] waddr, wdata, raddr, rdata, pd;
    logic [3:0] cx, cy;

    logic       start2, lv2, ready2;
    logic [5:0] la2, waddr2, raddr2;
    logic [7:0] ld2, wdata2, rdata2, pd2;
    logic       wen2, pv2, pf2, pl2, busy2, done2, lr2;
    logic [0:0] cx2, cy2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ref_window_scan_ctrl #(.DATA_WIDTH(8), .WIN_DIM(16), .BLK_DIM(4)) dut (
        .in_clk(clk), .in_rst(rst), .in_start(start),
        .in_load_valid(lv), .in_load_addr(la), .in_load_data(ld), .out_load_ready(lr),
        .out_mem_write_en(wen), .out_mem_write_addr(waddr), .out_mem_write_data(wdata),
        .out_mem_read_addr(raddr), .in_mem_read_data(rdata),
        .out_pix_valid(pv), .out_pix_data(pd), .in_pix_ready(ready),
        .out_pix_first(pf), .out_pix_last(pl), .out_cand_x(cx), .out_cand_y(cy),
        .out_busy(busy), .out_done(done)
    );

    ref_window_scan_ctrl #(.DATA_WIDTH(8), .WIN_DIM(8), .BLK_DIM(8)) dut2 (
        .in_clk(clk), .in_rst(rst), .in_start(start2),
        .in_load_valid(lv2), .in_load_addr(la2), .in_load_data(ld2), .out_load_ready(lr2),
        .out_mem_write_en(wen2), .out_mem_write_addr(waddr2), .out_mem_write_data(wdata2),
        .out_mem_read_addr(raddr2), .in_mem_read_data(rdata2),
        .out_pix_valid(pv2), .out_pix_data(pd2), .in_pix_ready(ready2),
        .out_pix_first(pf2), .out_pix_last(pl2), .out_cand_x(cx2), .out_cand_y(cy2),
        .out_busy(busy2), .out_done(done2)
    );

    logic [7:0] mem1 [256];
    logic [7:0] mem2 [64];

    always @(posedge clk) begin
        if (wen) mem1[waddr] <= wdata;
        rdata <= (wen && waddr == raddr) ? wdata : mem1[raddr];
        if (wen2) mem2[waddr2] <= wdata2;
        rdata2 <= (wen2 && waddr2 == raddr2) ? wdata2 : mem2[raddr2];
        cyc <= cyc + 1;
    end

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {data, first, last, cx, cy} of beat k when mem[a]=a (defaults 16/4, N=13).
    function automatic logic [17:0] beat_model(input int k);
        int cand, pix, cxm, cym, a;
        cand = k / 16;
        pix  = k % 16;
        cxm  = cand % 13;
        cym  = cand / 13;
        a    = (cym + pix / 4) * 16 + cxm + pix % 4;
        return {8'(a), pix == 0, pix == 15, 4'(cxm), 4'(cym)};
    endfunction

    logic        prev_stall = 1'b0;
    logic [17:0] prev_tag = '0;
    int          beat_idx = 0;

    always @(negedge clk) begin
        if (rst) begin
            beat_idx   = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("stall_hold", {pv, pd, pf, pl, cx, cy}, {1'b1, prev_tag});
            if (done) chk("beat_count", beat_idx, 2704);
            if (pv) begin
                chk($sformatf("beat%0d", beat_idx), {beat_idx < 2704, pd, pf, pl, cx, cy},
                    {1'b1, beat_model(beat_idx)});
                if (ready) beat_idx++;
            end
            prev_stall = pv && !ready;
            prev_tag   = {pd, pf, pl, cx, cy};
            if (!busy) beat_idx = 0;
        end
    end

    task automatic check_reset(input string name);
        @(negedge clk);
        chk({name, "_dut"}, {pv, pf, pl, cx, cy, busy, done, wen, raddr, lr}, 64'd1);
        chk({name, "_dut2"}, {pv2, pf2, pl2, cx2, cy2, busy2, done2, wen2, raddr2, lr2}, 64'd1);
    endtask

    task automatic wait_done(input int c, input int limit, output int when);
        when = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (done) begin
                when = cyc - c;
                break;
            end
        end
    endtask

    typedef struct {
        logic       st, lv, rdy;
        logic       ev;
        logic [7:0] ed;
        logic       ef, el;
        logic [3:0] ecx;
        logic [7:0] era;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic lvi, input logic rdy, input logic ev,
                                input int ed, input logic ef, input logic el, input int ecx,
                                input int era);
        vec_t v;
        v.st = st; v.lv = lvi; v.rdy = rdy; v.ev = ev; v.ed = 8'(ed);
        v.ef = ef; v.el = el; v.ecx = 4'(ecx); v.era = 8'(era);
        return v;
    endfunction

    vec_t vt [22];

    initial begin
        int c, when, stalls, k, i;
        logic found;

        // cycle-by-cycle from cycle 1 of a scan: start/load blocked, 2-cycle stall on beat 2,
        // crossing into candidate (0,1)
        vt[0]  = mk(1, 1, 1, 0,  0, 0, 0, 0,  0);
        vt[1]  = mk(0, 0, 1, 1,  0, 1, 0, 0,  1);
        vt[2]  = mk(1, 1, 1, 1,  1, 0, 0, 0,  2);
        vt[3]  = mk(0, 1, 0, 1,  2, 0, 0, 0,  2);
        vt[4]  = mk(0, 0, 0, 1,  2, 0, 0, 0,  2);
        vt[5]  = mk(0, 0, 1, 1,  2, 0, 0, 0,  3);
        vt[6]  = mk(0, 0, 1, 1,  3, 0, 0, 0, 16);
        vt[7]  = mk(0, 0, 1, 1, 16, 0, 0, 0, 17);
        vt[8]  = mk(0, 0, 1, 1, 17, 0, 0, 0, 18);
        vt[9]  = mk(0, 0, 1, 1, 18, 0, 0, 0, 19);
        vt[10] = mk(0, 0, 1, 1, 19, 0, 0, 0, 32);
        vt[11] = mk(0, 0, 1, 1, 32, 0, 0, 0, 33);
        vt[12] = mk(0, 0, 1, 1, 33, 0, 0, 0, 34);
        vt[13] = mk(0, 0, 1, 1, 34, 0, 0, 0, 35);
        vt[14] = mk(0, 0, 1, 1, 35, 0, 0, 0, 48);
        vt[15] = mk(0, 0, 1, 1, 48, 0, 0, 0, 49);
        vt[16] = mk(0, 0, 1, 1, 49, 0, 0, 0, 50);
        vt[17] = mk(0, 0, 1, 1, 50, 0, 0, 0, 51);
        vt[18] = mk(0, 0, 1, 1, 51, 0, 1, 0,  1);
        vt[19] = mk(0, 0, 1, 1,  1, 1, 0, 1,  2);
        vt[20] = mk(0, 0, 1, 1,  2, 0, 0, 1,  3);
        vt[21] = mk(0, 0, 1, 1,  3, 0, 0, 1,  4);

        rst = 1'b1; start = 1'b0; lv = 1'b0; la = '0; ld = '0; ready = 1'b1;
        start2 = 1'b0; lv2 = 1'b0; la2 = '0; ld2 = '0; ready2 = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_reset("reset_init");

        // window load mem[a] = a
        tick();
        for (int a = 0; a < 256; a++) begin
            lv = 1'b1; la = 8'(a); ld = 8'(a);
            @(negedge clk);
            chk($sformatf("load%0d", a), {lr, wen, waddr, wdata}, {1'b1, 1'b1, 8'(a), 8'(a)});
            tick();
        end
        lv = 1'b0;

        // table-driven opening of a scan
        start = 1'b1; c = cyc;
        tick();
        la = 8'h05; ld = 8'hEE;
        for (int r = 0; r < 22; r++) begin
            start = vt[r].st; lv = vt[r].lv; ready = vt[r].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d", r), {pv, pd, pf, pl, cx, cy, busy, lr, wen, raddr},
                {vt[r].ev, vt[r].ed, vt[r].ef, vt[r].el, vt[r].ecx, 4'd0, 1'b1, 1'b0, 1'b0, vt[r].era});
            tick();
        end
        start = 1'b0; lv = 1'b0; ready = 1'b1;
        wait_done(c, 4000, when);
        chk("scan1_done_cycle", when, 2708);
        chk("scan1_done_busy", {busy, pv}, 2'b00);

        // a load in the cycle after DONE is written
        tick();
        lv = 1'b1; la = 8'd7; ld = 8'h77;
        @(negedge clk);
        chk("post_done_ready", {lr, wen}, 2'b11);
        tick();
        lv = 1'b0;
        @(negedge clk);
        chk("post_done_write", mem1[7], 8'h77);
        tick();
        lv = 1'b1; ld = 8'd7;
        tick();
        lv = 1'b0;

        // random backpressure: done delay equals stall cycles
        start = 1'b1; c = cyc;
        tick();
        start = 1'b0; stalls = 0; when = -1;
        for (int n = 0; n < 10000; n++) begin
            ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done) begin
                when = cyc - c;
                break;
            end
            if (pv && !ready) stalls++;
            tick();
        end
        ready = 1'b1;
        chk("bp_done_cycle", when, 2706 + stalls);

        // reset at beat 500
        tick();
        start = 1'b1;
        tick();
        start = 1'b0; k = 0; found = 1'b0;
        for (int n = 0; n < 1000 && !found; n++) begin
            @(negedge clk);
            if (pv && k == 500) found = 1'b1;
            else begin
                if (pv && ready) k++;
                tick();
            end
        end
        chk("reach_beat500", found, 1'b1);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", {pv, busy, done}, 3'b000);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset("reset_mid");
        tick();
        start = 1'b1; c = cyc;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("restart_c1", {busy, pv, raddr}, {1'b1, 1'b0, 8'd0});
        tick();
        @(negedge clk);
        chk("restart_c2", {pv, pd, pf, cx, cy}, {1'b1, 8'd0, 1'b1, 4'd0, 4'd0});
        wait_done(c, 4000, when);
        chk("restart_done_cycle", when, 2706);

        // single-candidate instance 8x8 window, 8x8 block
        tick();
        for (int a = 0; a < 64; a++) begin
            lv2 = 1'b1; la2 = 6'(a); ld2 = 8'(a + 100);
            tick();
        end
        lv2 = 1'b0;
        start2 = 1'b1; c = cyc;
        tick();
        start2 = 1'b0; i = 0; when = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (pv2) begin
                chk($sformatf("p2_beat%0d", i), {pd2, pf2, pl2, cx2, cy2},
                    {8'(i + 100), i == 0, i == 63, 1'b0, 1'b0});
                i++;
            end
            if (done2) begin
                when = cyc - c;
                break;
            end
            tick();
        end
        chk("p2_beats", i, 64);
        chk("p2_done_cycle", when, 66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
